// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg
// Shared types for the cpu-side bus arbiter: instruction/data request and
// response structs, the merged core-bus structs, the access-size encoding
// and the arbiter state encoding.
package cbus_arbiter_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        msize_t      size;
        logic [7:0]  strobe;
        logic [31:0] addr;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter.sv
// cbus_arbiter
// Merges the cpu instruction and data ports onto one core-bus master port.
// One single-beat transaction is in flight at a time; the granted request is
// latched and held on creq until cresp.ready && cresp.last, and the response
// is steered back to the port that owns the grant.
//
// State table:
//   IDLE | no grant held; arbitrate incoming requests
//   IGNT | instruction port owns the bus, waiting for handshake
//   DGNT | data port owns the bus, waiting for handshake
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   ireq/iresp instruction port request / response
//   dreq/dresp data port request / response
//   creq/cresp merged core-bus request / response
//   busy       high while a grant is held
//   last_grant port of the last completed grant (0 = ibus, 1 = dbus)
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter bit FIXED_DPRIO   = 1'b1,
    parameter int IDATA_SEL_BIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp,
    output logic       busy,
    output logic       last_grant
);

    arb_state_t state_q, state_d;
    cbus_req_t  creq_q, creq_d;
    logic       last_grant_q, last_grant_d;
    logic       handshake;

    // 1 selects the data port. With both valid, round-robin picks the port
    // that did not win last time.
    function automatic logic grant_dbus(input logic i_v, input logic d_v,
                                        input logic last);
        if (i_v && d_v) begin
            return FIXED_DPRIO ? 1'b1 : ~last;
        end
        return d_v;
    endfunction

    // Multi-beat responses (ready without last) are not supported and are
    // simply treated as a stall.
    assign handshake = cresp.ready && cresp.last;

    always_comb begin
        state_d      = state_q;
        creq_d       = creq_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (ireq.valid || dreq.valid) begin
                    creq_d       = '0;
                    creq_d.valid = 1'b1;
                    if (grant_dbus(ireq.valid, dreq.valid, last_grant_q)) begin
                        state_d         = DGNT;
                        creq_d.is_write = (dreq.strobe != 8'h00);
                        creq_d.size     = dreq.size;
                        creq_d.strobe   = dreq.strobe;
                        creq_d.addr     = dreq.addr;
                        creq_d.data     = dreq.data;
                    end else begin
                        state_d     = IGNT;
                        creq_d.size = MSIZE4;
                        creq_d.addr = ireq.addr;
                    end
                end
            end
            IGNT, DGNT: begin
                if (handshake) begin
                    state_d      = IDLE;
                    creq_d.valid = 1'b0;
                    last_grant_d = (state_q == DGNT);
                end
            end
            default: begin
                state_d = IDLE;
                creq_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            creq_q       <= '0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            creq_q       <= creq_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Responses pulse only on the handshake cycle, and only if the owner is
    // still requesting; a requester that dropped valid gets nothing.
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (handshake && state_q == IGNT && ireq.valid) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = creq_q.addr[IDATA_SEL_BIT] ? cresp.data[63:32]
                                                       : cresp.data[31:0];
        end
        if (handshake && state_q == DGNT && dreq.valid) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = cresp.data;
        end
    end

    assign creq       = creq_q;
    assign busy       = (state_q != IDLE);
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter
// Directed bench for cbus_arbiter. u_fix uses fixed data priority, u_rr uses
// round-robin; each has its own stimulus. Inputs change 1 ns after a rising
// edge and outputs are sampled 1 ns after that.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    ibus_req_t  ireq_f, ireq_r;
    ibus_resp_t iresp_f, iresp_r;
    dbus_req_t  dreq_f, dreq_r;
    dbus_resp_t dresp_f, dresp_r;
    cbus_req_t  creq_f, creq_r;
    cbus_resp_t cresp_f, cresp_r;
    logic       busy_f, busy_r;
    logic       lg_f, lg_r;

    int checks;
    int failures;

    cbus_arbiter #(.FIXED_DPRIO(1'b1), .IDATA_SEL_BIT(2)) u_fix (
        .clk(clk), .rst(rst),
        .ireq(ireq_f), .iresp(iresp_f),
        .dreq(dreq_f), .dresp(dresp_f),
        .creq(creq_f), .cresp(cresp_f),
        .busy(busy_f), .last_grant(lg_f)
    );

    cbus_arbiter #(.FIXED_DPRIO(1'b0), .IDATA_SEL_BIT(2)) u_rr (
        .clk(clk), .rst(rst),
        .ireq(ireq_r), .iresp(iresp_r),
        .dreq(dreq_r), .dresp(dresp_r),
        .creq(creq_r), .cresp(cresp_r),
        .busy(busy_r), .last_grant(lg_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        ireq_f = '0; dreq_f = '0; cresp_f = '0;
        ireq_r = '0; dreq_r = '0; cresp_r = '0;
        tick();
        tick();
        rst = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_creq_valid", 64'(creq_f.valid), 64'd0);
            chk("idle_busy", 64'(busy_f), 64'd0);
            chk("idle_iresp", 64'(iresp_f), 64'd0);
            chk("idle_dresp", 64'(dresp_f), 64'd0);
        end
        chk("idle_last_grant", 64'(lg_f), 64'd0);

        // 2: instruction fetch, one stall beat (ready without last)
        ireq_f.valid = 1'b1;
        ireq_f.addr  = 32'h8000_0004;
        tick();
        chk("if_creq_valid", 64'(creq_f.valid), 64'd1);
        chk("if_creq_addr", 64'(creq_f.addr), 64'h8000_0004);
        chk("if_creq_size", 64'(creq_f.size), 64'(MSIZE4));
        chk("if_creq_write", 64'(creq_f.is_write), 64'd0);
        chk("if_busy", 64'(busy_f), 64'd1);
        cresp_f.ready = 1'b1;
        cresp_f.last  = 1'b0;
        cresp_f.data  = 64'h1111_2222_3333_4444;
        #1;
        chk("if_stall_no_ok", 64'(iresp_f.data_ok), 64'd0);
        tick();
        chk("if_stall_busy", 64'(busy_f), 64'd1);
        cresp_f = '0;
        tick();
        cresp_f.ready = 1'b1;
        cresp_f.last  = 1'b1;
        cresp_f.data  = 64'h1111_2222_3333_4444;
        #1;
        chk("if_data_ok", 64'(iresp_f.data_ok), 64'd1);
        chk("if_addr_ok", 64'(iresp_f.addr_ok), 64'd1);
        chk("if_data", 64'(iresp_f.data), 64'h1111_2222);
        chk("if_dresp_quiet", 64'(dresp_f), 64'd0);
        ireq_f.valid = 1'b0;
        tick();
        cresp_f = '0;
        #1;
        chk("if_done_valid", 64'(creq_f.valid), 64'd0);
        chk("if_done_busy", 64'(busy_f), 64'd0);
        chk("if_done_ok", 64'(iresp_f.data_ok), 64'd0);
        chk("if_done_lg", 64'(lg_f), 64'd0);

        // 3: simultaneous requests, data port wins
        ireq_f.valid = 1'b1;
        ireq_f.addr  = 32'h8000_0010;
        dreq_f.valid = 1'b1;
        dreq_f.addr  = 32'h8000_0020;
        dreq_f.size  = MSIZE8;
        dreq_f.strobe = 8'h00;
        tick();
        chk("sim_d_addr", 64'(creq_f.addr), 64'h8000_0020);
        chk("sim_d_size", 64'(creq_f.size), 64'(MSIZE8));
        chk("sim_d_write", 64'(creq_f.is_write), 64'd0);
        cresp_f.ready = 1'b1;
        cresp_f.last  = 1'b1;
        cresp_f.data  = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        chk("sim_d_ok", 64'(dresp_f.data_ok), 64'd1);
        chk("sim_d_data", dresp_f.data, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("sim_i_quiet", 64'(iresp_f), 64'd0);
        dreq_f.valid = 1'b0;
        tick();
        cresp_f = '0;
        #1;
        chk("sim_gap_valid", 64'(creq_f.valid), 64'd0);
        chk("sim_gap_lg", 64'(lg_f), 64'd1);
        tick();
        chk("sim_i_valid", 64'(creq_f.valid), 64'd1);
        chk("sim_i_addr", 64'(creq_f.addr), 64'h8000_0010);
        chk("sim_i_lg", 64'(lg_f), 64'd1);
        cresp_f.ready = 1'b1;
        cresp_f.last  = 1'b1;
        cresp_f.data  = 64'h1111_2222_3333_4444;
        #1;
        chk("sim_i_data", 64'(iresp_f.data), 64'h3333_4444);
        ireq_f.valid = 1'b0;
        tick();
        cresp_f = '0;
        #1;
        chk("sim_after_lg", 64'(lg_f), 64'd0);

        // 5: store, address changes mid-grant, new request on handshake cycle
        dreq_f.valid  = 1'b1;
        dreq_f.addr   = 32'h8000_1000;
        dreq_f.size   = MSIZE4;
        dreq_f.strobe = 8'h0F;
        dreq_f.data   = 64'h0000_0000_DEAD_BEEF;
        tick();
        chk("st_write", 64'(creq_f.is_write), 64'd1);
        chk("st_strobe", 64'(creq_f.strobe), 64'h0F);
        chk("st_data", creq_f.data, 64'h0000_0000_DEAD_BEEF);
        dreq_f.addr = 32'h8000_2000;
        tick();
        chk("st_addr_held", 64'(creq_f.addr), 64'h8000_1000);
        cresp_f.ready = 1'b1;
        cresp_f.last  = 1'b1;
        cresp_f.data  = 64'h0;
        ireq_f.valid  = 1'b1;
        ireq_f.addr   = 32'h8000_0040;
        #1;
        chk("st_ok", 64'(dresp_f.data_ok), 64'd1);
        dreq_f.valid = 1'b0;
        tick();
        cresp_f = '0;
        #1;
        chk("st_ok_pulse", 64'(dresp_f.data_ok), 64'd0);
        chk("hs_new_not_granted", 64'(busy_f), 64'd0);
        tick();
        chk("hs_new_granted", 64'(creq_f.addr), 64'h8000_0040);
        chk("hs_new_busy", 64'(busy_f), 64'd1);
        // requester drops valid mid-grant: response suppressed
        ireq_f.valid  = 1'b0;
        cresp_f.ready = 1'b1;
        cresp_f.last  = 1'b1;
        cresp_f.data  = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("drop_no_ok", 64'(iresp_f), 64'd0);
        tick();
        cresp_f = '0;
        #1;
        chk("drop_idle", 64'(busy_f), 64'd0);
        chk("drop_lg", 64'(lg_f), 64'd0);

        // 6: reset mid-grant, late response ignored
        dreq_f.valid  = 1'b1;
        dreq_f.addr   = 32'h8000_3000;
        dreq_f.strobe = 8'h00;
        tick();
        chk("rst_pre_busy", 64'(busy_f), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_creq_valid", 64'(creq_f.valid), 64'd0);
        chk("rst_busy", 64'(busy_f), 64'd0);
        dreq_f.valid = 1'b0;
        tick();
        rst = 1'b1;
        cresp_f.ready = 1'b1;
        cresp_f.last  = 1'b1;
        cresp_f.data  = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk("rst_late_no_pulse", 64'(dresp_f.data_ok), 64'd0);
        tick();
        cresp_f = '0;
        #1;
        chk("rst_after_busy", 64'(busy_f), 64'd0);

        // 4: round-robin; a lone D transaction first so I is next in line
        dreq_r.valid = 1'b1;
        dreq_r.addr  = 32'h9000_0000;
        dreq_r.size  = MSIZE8;
        tick();
        chk("rr_pre_addr", 64'(creq_r.addr), 64'h9000_0000);
        cresp_r.ready = 1'b1;
        cresp_r.last  = 1'b1;
        dreq_r.valid  = 1'b0;
        tick();
        cresp_r = '0;
        #1;
        chk("rr_pre_lg", 64'(lg_r), 64'd1);
        ireq_r.valid = 1'b1;
        ireq_r.addr  = 32'hA000_0000;
        dreq_r.valid = 1'b1;
        dreq_r.addr  = 32'hB000_0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant_addr", 64'(creq_r.addr),
                (k % 2 == 0) ? 64'hA000_0000 : 64'hB000_0000);
            chk("rr_grant_valid", 64'(creq_r.valid), 64'd1);
            cresp_r.ready = 1'b1;
            cresp_r.last  = 1'b1;
            tick();
            cresp_r = '0;
            #1;
            chk("rr_lg", 64'(lg_r), (k % 2 == 0) ? 64'd0 : 64'd1);
        end
        ireq_r.valid = 1'b0;
        dreq_r.valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Sits directly downstream of the cpu core's two memory ports, ireq/iresp and dreq/dresp.
- Merges them onto a single core-bus (cbus) master port toward the memory/cache side.
- Grants one transaction at a time, registers the granted request and holds it until the single-beat response completes.
- Routes that response back to the originating port.

Parameters:
- FIXED_DPRIO, 1, 1 = dbus always wins a simultaneous request; 0 = round-robin on last grant.
- IDATA_SEL_BIT, 2, address bit that selects the 32-bit instruction half of the 64-bit cbus data word.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- ireq  in  ibus_req_t  instruction request from cpu.
- iresp  out  ibus_resp_t  instruction response to cpu.
- dreq  in  dbus_req_t  data request from cpu.
- dresp  out  dbus_resp_t  data response to cpu.
- creq  out  cbus_req_t  merged request to memory.
- cresp  in  cbus_resp_t  memory response.
- busy  out  1  high while a grant is held.
- last_grant  out  1  0 = ibus, 1 = dbus; the last port granted.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst).
- Reset values: state=IDLE; creq all zero; iresp/dresp all zero; busy=0; last_grant=0. The latched request register is cleared.
- State machine IDLE:
  - No request valid: stay in IDLE.
  - Exactly one of ireq.valid / dreq.valid high: latch that request into creq_r and go to IGNT or DGNT.
  - Both high: FIXED_DPRIO=1 grants D. FIXED_DPRIO=0 grants the port opposite last_grant.
- Request timing: creq.valid rises on the cycle after the grant (registered output).
- Request latching, I grant: is_write=0, size=MSIZE4, strobe=0, addr=ireq.addr.
- Request latching, D grant: is_write=(dreq.strobe!=0); size, strobe, addr and data are copied from dreq.
- States IGNT and DGNT:
  - creq holds the latched value, stable, until the handshake cycle where cresp.ready && cresp.last.
  - On the handshake cycle the owning response gets addr_ok=1 and data_ok=1 for exactly that one cycle.
  - iresp.data = cresp.data word half selected by latched addr[IDATA_SEL_BIT] (1 = upper 32 bits).
  - dresp.data = cresp.data, all 64 bits.
  - The next cycle: state returns to IDLE, creq.valid drops to 0, last_grant updates.
- Non-owning port: its response outputs stay 0 throughout.
- Back-to-back grants: one IDLE cycle minimum between transactions, so the earliest new grant is 2 cycles after a handshake.
- Requester drops valid mid-grant:
  - This is illegal per protocol.
  - The transaction still completes on cbus and the response is discarded (addr_ok/data_ok suppressed).
  - No state corruption results.
- Requester changes addr mid-grant: ignored; the latched copy is used.
- Handshake in the same cycle a new request appears: the new request is not granted until IDLE.
- cresp.ready without cresp.last: this is a multi-beat case, unsupported. Treat it as a stall and keep waiting.
- Reset asserted mid-grant: immediate return to IDLE and creq.valid=0. The in-flight response is discarded.
- busy=1 in IGNT and DGNT.

Decomposition:
- Shared package common: ibus_req_t, ibus_resp_t, dbus_req_t, dbus_resp_t, cbus_req_t, cbus_resp_t, and the msize_t enum (MSIZE1/2/4/8).
- Local constants in common: an arb_state_t enum (IDLE, IGNT, DGNT).
- No sub-module. The grant select is an internal function.

Test Plan:
1. Reset release, no requests -> creq.valid=0 for 10 cycles; busy=0; iresp/dresp all zero.
2. Instruction fetch:
   - Stimulus: ireq.valid=1, addr=0x8000_0004; cresp ready+last 3 cycles after creq.valid, data=0x1111_2222_3333_4444.
   - Response: creq.addr=0x8000_0004 with size MSIZE4; iresp.data_ok=1 for one cycle with data=0x1111_2222.
3. Simultaneous requests:
   - Stimulus: ireq and dreq valid in the same cycle, FIXED_DPRIO=1.
   - Response: D granted first. After D's handshake plus one IDLE cycle, I is granted. last_grant reads 1 during the I transaction, then 0.
4. Round-robin, FIXED_DPRIO=0, both held valid continuously -> grants alternate I, D, I, D; no port receives two grants in a row.
5. Store:
   - Stimulus: dreq strobe=0x0F, data=0xDEAD_BEEF, addr=0x8000_1000; the cpu changes dreq.addr mid-grant.
   - Response: creq.is_write=1 and creq.addr stays 0x8000_1000; dresp.data_ok pulses for 1 cycle.
6. rst pulled low while in DGNT before the handshake -> creq.valid=0 within the same cycle and state=IDLE. A late cresp arriving after rst releases produces no dresp pulse.
